accel_servo_map: RTL

- Downstream consumer of the accelerometer SPI stage in the arm controller.
- Takes signed X/Y tilt samples and smooths each axis with a 4-sample moving average.
- Clamps and scales the result to a servo pulse width, and generates two 50 Hz servo PWM outputs (base and shoulder joints).
- Pulse widths update only at PWM period boundaries, so no glitched pulses are ever produced.

---
 rtl/accel_servo_map.sv | 129 ++++++++++++
 1 files changed

// File: rtl/accel_servo_map.sv
// Purpose: 4-sample moving average of X/Y tilt, clamped and scaled into two 50 Hz servo PWM outputs.
// Latency: sample accepted at cycle t -> pending width ready at t+3; active width loads at next PWM period start.
// Backpressure: sample_ready low for 2 cycles after an accept; samples offered while not ready are dropped and flag overrun.
module accel_servo_map #(
    parameter int PERIOD   = 1000000,
    parameter int CENTER   = 75000,
    parameter int SCALE    = 100,
    parameter int CLAMP    = 250,
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [15:0] data_x,
    input  logic [15:0] data_y,
    output logic        servo_x,
    output logic        servo_y,
    output logic [19:0] width_x,
    output logic [19:0] width_y,
    output logic        overrun
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 16 + AVG_LOG2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SUM   = 2'd1;
    localparam logic [1:0] ST_SCALE = 2'd2;

    logic [1:0]              state;
    logic signed [15:0]      lat_x, lat_y;
    logic signed [15:0]      ring_x [DEPTH];
    logic signed [15:0]      ring_y [DEPTH];
    logic [AVG_LOG2-1:0]     wr_ptr;
    logic signed [SUM_W-1:0] sum_x, sum_y;
    logic [19:0]             pend_x, pend_y;
    logic [19:0]             cnt;

    assign sample_ready = (state == ST_IDLE);

    // Average (floor division by shift), clamp, then map to a pulse width around CENTER.
    function automatic logic [19:0] to_width(input logic signed [SUM_W-1:0] sum);
        logic signed [SUM_W-1:0] avg;
        logic signed [31:0]      a;
        logic signed [31:0]      w;
        avg = sum >>> AVG_LOG2;
        a   = {{(32-SUM_W){avg[SUM_W-1]}}, avg};
        if (a > CLAMP)
            a = CLAMP;
        else if (a < -CLAMP)
            a = -CLAMP;
        w = CENTER + a * SCALE;
        return w[19:0];
    endfunction

    // Sample path: accept, update running sums/rings, then compute pending widths.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            overrun <= 1'b0;
            wr_ptr  <= '0;
            sum_x   <= '0;
            sum_y   <= '0;
            lat_x   <= '0;
            lat_y   <= '0;
            pend_x  <= 20'(CENTER);
            pend_y  <= 20'(CENTER);
            for (int i = 0; i < DEPTH; i++) begin
                ring_x[i] <= '0;
                ring_y[i] <= '0;
            end
        end else begin
            if (sample_valid && !sample_ready)
                overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        lat_x <= data_x;
                        lat_y <= data_y;
                        state <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    // Oldest sample leaves the window as the newest enters it.
                    sum_x <= sum_x + {{AVG_LOG2{lat_x[15]}}, lat_x}
                                   - {{AVG_LOG2{ring_x[wr_ptr][15]}}, ring_x[wr_ptr]};
                    sum_y <= sum_y + {{AVG_LOG2{lat_y[15]}}, lat_y}
                                   - {{AVG_LOG2{ring_y[wr_ptr][15]}}, ring_y[wr_ptr]};
                    ring_x[wr_ptr] <= lat_x;
                    ring_y[wr_ptr] <= lat_y;
                    wr_ptr <= wr_ptr + 1'b1;
                    state  <= ST_SCALE;
                end
                ST_SCALE: begin
                    pend_x <= to_width(sum_x);
                    pend_y <= to_width(sum_y);
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // PWM counter; active widths only reload at period start or while held disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            width_x <= 20'(CENTER);
            width_y <= 20'(CENTER);
        end else if (!enable) begin
            cnt     <= '0;
            width_x <= pend_x;
            width_y <= pend_y;
        end else if (cnt == 20'(PERIOD - 1)) begin
            cnt     <= '0;
            width_x <= pend_x;
            width_y <= pend_y;
        end else begin
            cnt <= cnt + 20'd1;
        end
    end

    // Outputs are low while disabled or in reset, so the first enabled cycle (cnt = 0) is already high.
    assign servo_x = enable & ~rst & (cnt < width_x);
    assign servo_y = enable & ~rst & (cnt < width_y);

endmodule
